// File: rtl/arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen_if.sv
// BIST sequencer bus: start/hold control, array strobes and address, read-back data and result flags.
// The sequencer uses the master view and the array side uses the slave view.
interface arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 70
);
  logic                  bist_start;
  logic                  bist_hold;
  logic [DATA_WIDTH-1:0] bist_rd_data;
  logic [ADDR_WIDTH-1:0] bist_addr;
  logic                  bist_wr_en;
  logic                  bist_rd_en;
  logic [DATA_WIDTH-1:0] bist_wr_data;
  logic                  bist_busy;
  logic                  bist_done;
  logic                  bist_fail;
  logic [ADDR_WIDTH-1:0] bist_fail_addr;

  modport master (
    input  bist_start, bist_hold, bist_rd_data,
    output bist_addr, bist_wr_en, bist_rd_en, bist_wr_data,
           bist_busy, bist_done, bist_fail, bist_fail_addr
  );

  modport slave (
    output bist_start, bist_hold, bist_rd_data,
    input  bist_addr, bist_wr_en, bist_rd_en, bist_wr_data,
           bist_busy, bist_done, bist_fail, bist_fail_addr
  );
endinterface

// File: rtl/arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen.sv
// March C- address/strobe sequencer for the array BIST path, with a one-stage
// read-back comparator that latches the first failing row.
module arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen #(
  parameter int DEPTH      = 144,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 70
) (
  input  logic clk,
  input  logic rst_b,
  arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_reg, state_next;
  logic [2:0]            elem_reg, elem_next;
  logic                  op_reg, op_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  wr_en_reg, wr_en_next;
  logic                  rd_en_reg, rd_en_next;
  logic                  wr_bit_reg, wr_bit_next;
  logic                  exp_bit_reg, exp_bit_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  fail_reg, fail_next;
  logic [ADDR_WIDTH-1:0] fail_addr_reg, fail_addr_next;

  logic                  start_ok;
  logic                  elem_down;
  logic                  single_op;
  logic                  op_is_wr;
  logic                  op_wbit;
  logic                  op_rbit;
  logic                  last_op;
  logic                  last_addr;
  logic [DATA_WIDTH-1:0] miscmp;

  // Element decode: E0 is w0 only, E5 is r0 only, E1..E4 are read-then-write.
  assign start_ok  = bus.bist_start && (state_reg != ST_RUN);
  assign elem_down = (elem_reg == 3'd3) || (elem_reg == 3'd4);
  assign single_op = (elem_reg == 3'd0) || (elem_reg == 3'd5);
  assign op_is_wr  = (elem_reg == 3'd0) || op_reg;
  assign op_wbit   = (elem_reg == 3'd1) || (elem_reg == 3'd3);
  assign op_rbit   = (elem_reg == 3'd2) || (elem_reg == 3'd4);
  assign last_op   = single_op || op_reg;
  assign last_addr = elem_down ? (cnt_reg == '0) : (cnt_reg == LAST_ADDR);

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_cmp
      assign miscmp[gi] = bus.bist_rd_data[gi] ^ exp_bit_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg     <= ST_IDLE;
      elem_reg      <= '0;
      op_reg        <= 1'b0;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
      wr_bit_reg    <= 1'b0;
      exp_bit_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      fail_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      elem_reg      <= elem_next;
      op_reg        <= op_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wr_en_reg     <= wr_en_next;
      rd_en_reg     <= rd_en_next;
      wr_bit_reg    <= wr_bit_next;
      exp_bit_reg   <= exp_bit_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
      fail_addr_reg <= fail_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    elem_next      = elem_reg;
    op_next        = op_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wr_en_next     = 1'b0;
    rd_en_next     = 1'b0;
    wr_bit_next    = wr_bit_reg;
    exp_bit_next   = exp_bit_reg;
    busy_next      = (state_reg == ST_RUN);
    done_next      = done_reg || (state_reg == ST_DONE);
    fail_next      = fail_reg;
    fail_addr_next = fail_addr_reg;

    // The output registers double as the compare stage for the read issued last cycle.
    if (rd_en_reg && (|miscmp) && !fail_reg) begin
      fail_next      = 1'b1;
      fail_addr_next = addr_reg;
    end

    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_next     = ST_RUN;
          elem_next      = '0;
          op_next        = 1'b0;
          cnt_next       = '0;
          done_next      = 1'b0;
          fail_next      = 1'b0;
          fail_addr_next = '0;
        end
      end
      ST_RUN: begin
        if (!bus.bist_hold) begin
          addr_next  = cnt_reg;
          wr_en_next = op_is_wr;
          rd_en_next = !op_is_wr;
          if (op_is_wr) begin
            wr_bit_next = op_wbit;
          end else begin
            exp_bit_next = op_rbit;
          end

          if (!last_op) begin
            op_next = 1'b1;
          end else begin
            op_next = 1'b0;
            if (!last_addr) begin
              cnt_next = elem_down ? cnt_reg - ADDR_WIDTH'(1) : cnt_reg + ADDR_WIDTH'(1);
            end else if (elem_reg == 3'd5) begin
              state_next = ST_DONE;
            end else begin
              // E3 and E4 descend, so entering them starts from the top row.
              elem_next = elem_reg + 3'd1;
              cnt_next  = ((elem_reg == 3'd2) || (elem_reg == 3'd3)) ? LAST_ADDR : '0;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.bist_addr      = addr_reg;
  assign bus.bist_wr_en     = wr_en_reg;
  assign bus.bist_rd_en     = rd_en_reg;
  assign bus.bist_wr_data   = {DATA_WIDTH{wr_bit_reg}};
  assign bus.bist_busy      = busy_reg;
  assign bus.bist_done      = done_reg;
  assign bus.bist_fail      = fail_reg;
  assign bus.bist_fail_addr = fail_addr_reg;

endmodule

// File: tb/tb_arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen.sv
// Directed bench for the March C- BIST sequencer: a 144-row instance with a mirrored
// array model and a 2-row instance checked against a hand-written address table.
module tb_arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen;

  localparam int D   = 144;
  localparam int AW  = 8;
  localparam int DW  = 70;
  localparam int D2  = 2;
  localparam int AW2 = 1;
  localparam int DW2 = 8;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW))  bus ();
  arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen_if #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW2)) bus2 ();

  arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen #(.DEPTH(D), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen #(.DEPTH(D2), .ADDR_WIDTH(AW2), .DATA_WIDTH(DW2)) dut2 (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus2)
  );

  // Array models: write on the strobe, combinational read so data is valid the cycle after rd_en.
  logic          mem  [D];
  logic          mem2 [D2];
  logic [DW-1:0] inj_mask;

  always @(posedge clk) if (bus.bist_wr_en)  mem[bus.bist_addr]   <= bus.bist_wr_data[0];
  always @(posedge clk) if (bus2.bist_wr_en) mem2[bus2.bist_addr] <= bus2.bist_wr_data[0];

  assign bus.bist_rd_data  = (bus.bist_rd_en  ? {DW{mem[bus.bist_addr]}}    : '0) ^ inj_mask;
  assign bus2.bist_rd_data =  bus2.bist_rd_en ? {DW2{mem2[bus2.bist_addr]}} : '0;

  // Hand-computed DEPTH=2 sequence: E0 up, E1/E2 up, E3/E4 down, E5 up.
  int exp_a2 [20] = '{0,1, 0,0,1,1, 0,0,1,1, 1,1,0,0, 1,1,0,0, 0,1};
  int exp_w2 [20] = '{1,1, 0,1,0,1, 0,1,0,1, 0,1,0,1, 0,1,0,1, 0,0};

  int tests_run    = 0;
  int tests_failed = 0;

  int            ops_seen, seq_errs, hold_errs, abort_errs, done_edge;
  logic          busy_first, done_first, fail_first, fail_end;
  logic [AW-1:0] fail_addr_end;

  // Reference: March C- operation k decoded from position alone.
  function automatic void model_op(input int k, input int depth,
                                   output int addr, output bit is_wr, output bit wbit);
    int e, j;
    if (k < depth) begin
      addr = k; is_wr = 1'b1; wbit = 1'b0;
    end else if (k >= 9 * depth) begin
      addr = k - 9 * depth; is_wr = 1'b0; wbit = 1'b0;
    end else begin
      e     = 1 + (k - depth) / (2 * depth);
      j     = (k - depth) % (2 * depth);
      addr  = (e == 3 || e == 4) ? depth - 1 - j / 2 : j / 2;
      is_wr = (j % 2) == 1;
      wbit  = (e == 1 || e == 3);
    end
  endfunction

  task automatic run_main(input string name, input int hold_k, input int hold_len,
                          input int glitch_k, input int inj_a, input int inj_b, input int abort_k);
    int            addr;
    bit            is_wr, wbit;
    int            hold_cnt;
    logic [AW-1:0] last_addr;
    last_addr = '0;
    hold_cnt  = 0;
    ops_seen = 0; seq_errs = 0; hold_errs = 0; abort_errs = 0; done_edge = -1;
    busy_first = 1'b0; done_first = 1'b1; fail_first = 1'b1;
    bus.bist_start = 1'b1;
    @(posedge clk); #1;
    bus.bist_start = 1'b0;
    for (int e = 1; e <= 1600; e++) begin
      @(posedge clk); #1;
      inj_mask = '0;
      if (bus.bist_start) bus.bist_start = 1'b0;
      if (e == 1) begin
        busy_first = bus.bist_busy; done_first = bus.bist_done; fail_first = bus.bist_fail;
      end
      if (bus.bist_wr_en && bus.bist_rd_en) seq_errs++;
      if (hold_cnt > 0) begin
        if (bus.bist_wr_en || bus.bist_rd_en || bus.bist_addr !== last_addr || !bus.bist_busy)
          hold_errs++;
        hold_cnt--;
        if (hold_cnt == 0) bus.bist_hold = 1'b0;
      end else if (bus.bist_wr_en || bus.bist_rd_en) begin
        model_op(ops_seen, D, addr, is_wr, wbit);
        if (bus.bist_addr !== AW'(addr) || bus.bist_wr_en !== is_wr) seq_errs++;
        if (is_wr && bus.bist_wr_data !== {DW{wbit}}) seq_errs++;
        if (ops_seen == inj_a || ops_seen == inj_b) inj_mask = DW'(1) << 5;
        last_addr = bus.bist_addr;
        ops_seen++;
        if (ops_seen == hold_k) begin bus.bist_hold = 1'b1; hold_cnt = hold_len; end
        if (ops_seen == glitch_k) bus.bist_start = 1'b1;
        if (ops_seen == abort_k) begin
          rst_b = 1'b0;
          #1;
          if ({bus.bist_addr, bus.bist_wr_en, bus.bist_rd_en, bus.bist_wr_data, bus.bist_busy,
               bus.bist_done, bus.bist_fail, bus.bist_fail_addr} !== '0) abort_errs++;
          $display("[TB] run %s: aborted after %0d ops, output errors=%0d", name, ops_seen, abort_errs);
          return;
        end
      end
      if (bus.bist_done) begin
        done_edge = e;
        break;
      end
    end
    fail_end      = bus.bist_fail;
    fail_addr_end = bus.bist_fail_addr;
    $display("[TB] run %s: ops=%0d done_edge=%0d seq_errs=%0d hold_errs=%0d fail=%0b fail_addr=%0d",
             name, ops_seen, done_edge, seq_errs, hold_errs, fail_end, fail_addr_end);
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({bus.bist_addr, bus.bist_wr_en, bus.bist_rd_en, bus.bist_wr_data, bus.bist_busy,
         bus.bist_done, bus.bist_fail, bus.bist_fail_addr} !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got addr=%0d busy=%0b done=%0b fail=%0b expected all 0",
                               bus.bist_addr, bus.bist_busy, bus.bist_done, bus.bist_fail);
    end
    tests_run++;
    if ({bus2.bist_addr, bus2.bist_wr_en, bus2.bist_rd_en, bus2.bist_busy, bus2.bist_done} !== '0) begin
      tests_failed++; $display("FAIL reset_outputs_d2: got busy=%0b done=%0b expected 0", bus2.bist_busy, bus2.bist_done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.bist_busy !== 1'b0 || bus.bist_done !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset: got busy=%0b done=%0b expected 0 0", bus.bist_busy, bus.bist_done);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_clean_run();
    run_main("clean", -1, 0, -1, -1, -1, -1);
    tests_run++;
    if (ops_seen !== 1440) begin tests_failed++; $display("FAIL clean_ops: got %0d expected 1440", ops_seen); end
    tests_run++;
    if (seq_errs !== 0) begin tests_failed++; $display("FAIL clean_sequence: got %0d errors expected 0", seq_errs); end
    tests_run++;
    if (done_edge !== 1441) begin tests_failed++; $display("FAIL clean_done_edge: got %0d expected 1441", done_edge); end
    tests_run++;
    if (busy_first !== 1'b1) begin tests_failed++; $display("FAIL clean_busy_rise: got %0b expected 1", busy_first); end
    tests_run++;
    if (bus.bist_busy !== 1'b0) begin tests_failed++; $display("FAIL clean_busy_fall: got %0b expected 0", bus.bist_busy); end
    tests_run++;
    if (fail_end !== 1'b0) begin tests_failed++; $display("FAIL clean_fail: got %0b expected 0", fail_end); end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.bist_done !== 1'b1) begin tests_failed++; $display("FAIL done_level: got %0b expected 1", bus.bist_done); end
  endtask

  task automatic test_fail_inject();
    // 806: E3 r0 at row 100; 1254: E4 r1 at row 20.
    run_main("inject", -1, 0, -1, 806, 1254, -1);
    tests_run++;
    if (fail_end !== 1'b1) begin tests_failed++; $display("FAIL inject_fail: got %0b expected 1", fail_end); end
    tests_run++;
    if (fail_addr_end !== AW'(100)) begin tests_failed++; $display("FAIL inject_fail_addr: got %0d expected 100", fail_addr_end); end
    tests_run++;
    if (done_edge !== 1441) begin tests_failed++; $display("FAIL inject_done_edge: got %0d expected 1441", done_edge); end
  endtask

  task automatic test_hold();
    run_main("hold", 500, 3, -1, -1, -1, -1);
    tests_run++;
    if (fail_first !== 1'b0 || done_first !== 1'b0) begin
      tests_failed++; $display("FAIL start_clears: got fail=%0b done=%0b expected 0 0", fail_first, done_first);
    end
    tests_run++;
    if (hold_errs !== 0) begin tests_failed++; $display("FAIL hold_freeze: got %0d errors expected 0", hold_errs); end
    tests_run++;
    if (seq_errs !== 0 || ops_seen !== 1440) begin
      tests_failed++; $display("FAIL hold_sequence: got errs=%0d ops=%0d expected 0 1440", seq_errs, ops_seen);
    end
    tests_run++;
    if (done_edge !== 1444) begin tests_failed++; $display("FAIL hold_done_edge: got %0d expected 1444", done_edge); end
    tests_run++;
    if (fail_end !== 1'b0) begin tests_failed++; $display("FAIL hold_fail: got %0b expected 0", fail_end); end
  endtask

  task automatic test_start_ignored();
    run_main("glitch", -1, 0, 10, -1, -1, -1);
    tests_run++;
    if (seq_errs !== 0 || ops_seen !== 1440) begin
      tests_failed++; $display("FAIL glitch_sequence: got errs=%0d ops=%0d expected 0 1440", seq_errs, ops_seen);
    end
    tests_run++;
    if (done_edge !== 1441) begin tests_failed++; $display("FAIL glitch_done_edge: got %0d expected 1441", done_edge); end
  endtask

  task automatic test_reset_mid_run();
    run_main("abort", -1, 0, -1, -1, -1, 700);
    tests_run++;
    if (abort_errs !== 0) begin tests_failed++; $display("FAIL abort_outputs: got %0d nonzero expected 0", abort_errs); end
    tests_run++;
    if (ops_seen !== 700) begin tests_failed++; $display("FAIL abort_ops: got %0d expected 700", ops_seen); end
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.bist_busy !== 1'b0 || bus.bist_done !== 1'b0) begin
      tests_failed++; $display("FAIL abort_idle: got busy=%0b done=%0b expected 0 0", bus.bist_busy, bus.bist_done);
    end
    run_main("after_abort", -1, 0, -1, -1, -1, -1);
    tests_run++;
    if (seq_errs !== 0 || ops_seen !== 1440) begin
      tests_failed++; $display("FAIL rerun_sequence: got errs=%0d ops=%0d expected 0 1440", seq_errs, ops_seen);
    end
    tests_run++;
    if (done_edge !== 1441 || fail_end !== 1'b0) begin
      tests_failed++; $display("FAIL rerun_done: got edge=%0d fail=%0b expected 1441 0", done_edge, fail_end);
    end
  endtask

  task automatic test_depth2(input int hold_edges, input int exp_done);
    int n, errs, done_e;
    n = 0; errs = 0; done_e = -1;
    bus2.bist_start = 1'b1;
    bus2.bist_hold  = (hold_edges > 0);
    @(posedge clk); #1;
    bus2.bist_start = 1'b0;
    if (hold_edges <= 1) bus2.bist_hold = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e < hold_edges && (bus2.bist_wr_en || bus2.bist_rd_en)) errs++;
      if (e == hold_edges - 1) bus2.bist_hold = 1'b0;
      if (bus2.bist_wr_en && bus2.bist_rd_en) errs++;
      if (bus2.bist_wr_en || bus2.bist_rd_en) begin
        if (n >= 20) errs++;
        else if (bus2.bist_addr !== AW2'(exp_a2[n]) || bus2.bist_wr_en !== exp_w2[n][0]) errs++;
        n++;
      end
      if (bus2.bist_done) begin done_e = e; break; end
    end
    $display("[TB] run depth2 hold=%0d: ops=%0d done_edge=%0d errs=%0d fail=%0b",
             hold_edges, n, done_e, errs, bus2.bist_fail);
    tests_run++;
    if (n !== 20 || errs !== 0) begin tests_failed++; $display("FAIL d2_sequence: got ops=%0d errs=%0d expected 20 0", n, errs); end
    tests_run++;
    if (done_e !== exp_done) begin tests_failed++; $display("FAIL d2_done_edge: got %0d expected %0d", done_e, exp_done); end
    tests_run++;
    if (bus2.bist_fail !== 1'b0) begin tests_failed++; $display("FAIL d2_fail: got %0b expected 0", bus2.bist_fail); end
  endtask

  initial begin
    bus.bist_start  = 1'b0;
    bus.bist_hold   = 1'b0;
    bus2.bist_start = 1'b0;
    bus2.bist_hold  = 1'b0;
    inj_mask        = '0;
    test_reset();
    test_clean_run();
    test_fail_inject();
    test_hold();
    test_start_ignored();
    test_reset_mid_run();
    test_depth2(0, 21);
    test_depth2(2, 22);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen.md
# arf070b144e1r1w0cbbeheaa4acw_bist_addr_gen

March C- sequencer for the array BIST path. It produces the per-cycle binary row address that feeds the BIST one-hot decoder, along with write/read strobes, write data and expected data. It sits directly upstream of the decoder. It also compares read data returned from the array and records the first failing address.

## Interface
- DEPTH, 144: number of array rows; valid range 2..2^ADDR_WIDTH.
- ADDR_WIDTH, 8: width of bist_addr; must equal the decoder IN_WIDTH.
- DATA_WIDTH, 70: array word width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- bist_start  in  1  single-cycle request; honoured only in IDLE or DONE.
- bist_hold  in  1  stall; freezes sequencing while high.
- bist_rd_data  in  DATA_WIDTH  array read data, valid exactly 1 cycle after bist_rd_en.
- bist_addr  out  ADDR_WIDTH  binary row address to the decoder.
- bist_wr_en  out  1  write strobe.
- bist_rd_en  out  1  read strobe.
- bist_wr_data  out  DATA_WIDTH  write data; all bits equal the pattern bit.
- bist_busy  out  1  high while the sequence runs, including hold.
- bist_done  out  1  level; high from completion until the next accepted start.
- bist_fail  out  1  sticky miscompare flag.
- bist_fail_addr  out  ADDR_WIDTH  address of the first miscompare.

## Operation
- FSM states: IDLE -> RUN -> DONE. An accepted start leaves DONE and enters RUN.
- In RUN, the block steps through six March C- elements. Each operation takes 1 cycle:
  - E0 ⇑ (w0)
  - E1 ⇑ (r0, w1)
  - E2 ⇑ (r1, w0)
  - E3 ⇓ (r0, w1)
  - E4 ⇓ (r1, w0)
  - E5 ⇑ (r0)
- ⇑ elements count 0..DEPTH-1. ⇓ elements count DEPTH-1..0.
- The address wraps at the DEPTH boundary on an element change, never at 2^ADDR_WIDTH. bist_addr is never ≥ DEPTH.
- Total operations = 10·DEPTH (1440 at the default DEPTH).
- All outputs are registered. At most one of bist_wr_en and bist_rd_en is high in any cycle.
- Write data is the element's write bit replicated across DATA_WIDTH.
- Compare stage:
  - The expected bit and address of each read are pipelined by 1 stage.
  - The next cycle compares bist_rd_data against the replicated expected bit.
  - On a mismatch with bist_fail low: set bist_fail and load bist_fail_addr.
  - Later mismatches do not change either output.
- Accepted start: clears bist_fail, bist_fail_addr and bist_done; resets the element, operation and address counters.
- bist_start while in RUN is ignored.
- On the last operation, the FSM moves to DONE.
- Reset, whether idle or mid-run: all outputs are 0 asynchronously and the FSM returns to IDLE. Reads in flight are discarded; no fail is recorded for them.

## Timing
- Let bist_start be sampled high at edge N.
  - Operation k (0-based) is presented on the outputs after edge N+1+k, assuming no hold.
  - bist_busy rises at edge N+1.
- Read data for a read issued after edge M is sampled at edge M+1. A fail update is visible after edge M+1.
- The last operation is presented after edge N+1440. Its compare happens at edge N+1441.
- At edge N+1441:
  - bist_busy falls.
  - bist_done rises.
  - The final bist_fail value is valid.
- bist_hold sampled high at edge H:
  - After edge H, bist_wr_en and bist_rd_en are 0.
  - bist_addr and bist_wr_data hold their values.
  - Counters freeze.
  - A read issued before edge H is still compared at edge H.
  - Sequencing resumes with the next operation after the first edge at which hold is sampled low.
  - Each hold cycle adds exactly 1 cycle of latency.
- bist_hold outside RUN has no effect.
- Start and hold high in the same cycle from IDLE: the start is accepted and the first operation is deferred until hold drops.

## Test plan
- Clean run, DEPTH=144, bist_rd_data mirrors written data → 1440 operations, then:
  - address sequence is 0..143, 0..143, 0..143, 143..0, 143..0, 0..143;
  - bist_done rises at N+1441;
  - bist_fail = 0.
- Inject a flipped bit 5 on the E3 read at address 100 → bist_fail = 1 and bist_fail_addr = 100. A second injection at address 20 in E4 leaves bist_fail_addr = 100.
- Pulse bist_hold for 3 cycles mid-E2 → no strobes during hold, no skipped or repeated address, and done arrives at N+1444.
- Assert rst_b low at operation 700, then start again → all outputs are 0 immediately, and the fresh run completes clean at 1440 operations.
- Pulse bist_start at operation 10 of a run → ignored, and timing is unchanged.
- DEPTH=2 with ADDR_WIDTH=1 → 20 operations with addresses only 0 or 1, and done at N+21.
